// File: rtl/uart_tx_port.sv
// uart_tx_port: memory-mapped 8N1 UART transmitter with a byte FIFO and a STATUS register.
// Define UART_TX_IRQ_EN to build the sticky FIFO-drained interrupt on tx_irq.
`ifndef Art_base
`define Art_base 64'h0000_0000_1000_0000
`endif

module uart_tx_port #(
   parameter logic [63:0] BASE_ADDR  = `Art_base,
   parameter int          CLK_HZ     = 50_000_000,
   parameter int          BAUD       = 115_200,
   parameter int          FIFO_DEPTH = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [63:0] bus_address,
   input  logic [63:0] bus_write_data,
   input  logic        bus_write_enable,
   input  logic        bus_read_enable,
   output logic [63:0] bus_read_data,
   output logic        uart_tx,
   output logic        tx_irq
);
   localparam int DIV = CLK_HZ / BAUD;
   localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int PW  = $clog2(FIFO_DEPTH);
   localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
   localparam logic [PW:0]   DEPTH_C  = FIFO_DEPTH[PW:0];

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state_reg, state_next;
   logic [CW-1:0] baud_reg, baud_next;
   logic [2:0]    bit_reg, bit_next;
   logic [7:0]    shift_reg;
   logic          tx_next;
   logic [7:0]    mem [FIFO_DEPTH];
   logic [PW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [PW:0]   count_reg;
   logic          overflow_reg;

   logic sel_data, sel_status, full, empty, push, pop, tick, busy;
   logic [4:0]  count5;
   logic [63:0] status_word;
   logic        unused_bits;

   assign sel_data    = (bus_address == BASE_ADDR);
   assign sel_status  = (bus_address == BASE_ADDR + 64'd8);
   assign full        = (count_reg == DEPTH_C);
   assign empty       = (count_reg == '0);
   // Fullness is judged before any same-cycle pop, so a store to a full FIFO is always dropped.
   assign push        = bus_write_enable && sel_data && !full;
   assign tick        = (baud_reg == DIV_LAST);
   assign busy        = (state_reg != IDLE);
   assign count5      = 5'(count_reg);
   assign status_word = {51'b0, count5, 4'b0, overflow_reg, busy, empty, full};
   assign unused_bits = ^bus_write_data[63:8];

   always_comb begin
      state_next = state_reg;
      baud_next  = baud_reg;
      bit_next   = bit_reg;
      pop        = 1'b0;
      tx_next    = 1'b1;
      case (state_reg)
         IDLE: begin
            if (!empty) begin
               pop        = 1'b1;
               baud_next  = '0;
               state_next = START;
            end
         end
         START: begin
            tx_next   = 1'b0;
            baud_next = tick ? '0 : baud_reg + 1'b1;
            if (tick) begin
               state_next = DATA;
               bit_next   = 3'd0;
            end
         end
         DATA: begin
            tx_next   = shift_reg[0];
            baud_next = tick ? '0 : baud_reg + 1'b1;
            if (tick) begin
               bit_next = bit_reg + 3'd1;
               if (bit_reg == 3'd7) state_next = STOP;
            end
         end
         STOP: begin
            baud_next = tick ? '0 : baud_reg + 1'b1;
            if (tick) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg <= IDLE;
         baud_reg  <= '0;
         bit_reg   <= '0;
         shift_reg <= '0;
         uart_tx   <= 1'b1;
      end else begin
         state_reg <= state_next;
         baud_reg  <= baud_next;
         bit_reg   <= bit_next;
         uart_tx   <= tx_next;
         if (pop)
            shift_reg <= mem[rd_ptr_reg];
         else if (state_reg == DATA && tick)
            shift_reg <= {1'b0, shift_reg[7:1]};
      end
   end

   // Storage carries no reset so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr_reg] <= bus_write_data[7:0];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         count_reg     <= '0;
         overflow_reg  <= 1'b0;
         bus_read_data <= '0;
      end else begin
         if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
         case ({push, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
         if (bus_write_enable && sel_data && full)
            overflow_reg <= 1'b1;
         else if (bus_write_enable && sel_status && bus_write_data[3])
            overflow_reg <= 1'b0;
         if (bus_read_enable)
            bus_read_data <= sel_status ? status_word : 64'd0;
      end
   end

`ifdef UART_TX_IRQ_EN
   logic irq_reg, irq_set, irq_clr;
   assign irq_set = (state_reg == STOP) && tick && empty && !push;
   assign irq_clr = bus_write_enable && sel_status && bus_write_data[4];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)       irq_reg <= 1'b0;
      else if (irq_clr) irq_reg <= 1'b0;
      else if (irq_set) irq_reg <= 1'b1;
   end
   assign tx_irq = irq_reg;
`else
   assign tx_irq = 1'b0;
`endif

endmodule
